// File: rtl/fpcvt_seq_ctrl.sv
// fpcvt_seq_ctrl: multi-cycle 12-bit two's-complement to {S,E,F} (value = F * 2^E) converter with valid/ready in and out
//   clk, rst_n (async active-low) | in_valid, in_ready, D[11:0] | out_valid, out_ready, S, E[2:0], F[3:0], sat
module fpcvt_seq_ctrl #(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] D,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        S,
  output logic [2:0]  E,
  output logic [3:0]  F,
  output logic        sat
);
  typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, DONE} state_t;
  state_t state, state_n;
  logic [11:0] d_q;
  logic [10:0] mag, mag_abs;
  logic [2:0]  exp_q, e_rnd;
  logic        sgn, sat_i, rb, ovf;
  logic [4:0]  f_sum;
  logic [3:0]  e_inc, f_rnd;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  // -2048 has no positive 11-bit twin, so it clamps to the largest magnitude
  assign mag_abs = d_q == 12'h800 ? 11'h7FF : d_q[11] ? ~d_q[10:0] + 11'd1 : d_q[10:0];
  assign rb      = ROUND_EN & mag[6];
  assign f_sum   = {1'b0, mag[10:7]} + {4'd0, rb};
  // mantissa carry renormalises to 1000 and bumps the exponent; past 7 it saturates
  assign e_inc   = {1'b0, exp_q} + {3'd0, f_sum[4]};
  assign ovf     = e_inc[3];
  assign f_rnd   = ovf ? 4'hF : f_sum[4] ? 4'h8 : f_sum[3:0];
  assign e_rnd   = ovf ? 3'd7 : e_inc[2:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = in_valid ? ABS : IDLE;
      ABS:     state_n = NORM;
      NORM:    state_n = (mag[10] || exp_q == 3'd0) ? ROUND : NORM;
      ROUND:   state_n = DONE;
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d_q   <= '0;
      mag   <= '0;
      exp_q <= '0;
      sgn   <= 1'b0;
      sat_i <= 1'b0;
      S     <= 1'b0;
      E     <= '0;
      F     <= '0;
      sat   <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) d_q <= D;
      if (state == ABS) begin
        sgn   <= d_q[11];
        mag   <= mag_abs;
        exp_q <= 3'd7;
        sat_i <= d_q == 12'h800;
      end
      if (state == NORM && !mag[10] && exp_q != 3'd0) begin
        mag   <= {mag[9:0], 1'b0};
        exp_q <= exp_q - 3'd1;
      end
      if (state == ROUND) begin
        S   <= sgn;
        E   <= e_rnd;
        F   <= f_rnd;
        sat <= sat_i | ovf;
      end
    end
endmodule

// File: tb/tb_fpcvt_seq_ctrl.sv
// tb_fpcvt_seq_ctrl: directed plus random checks of fpcvt_seq_ctrl (rounding and truncating builds) against an arithmetic model
module tb_fpcvt_seq_ctrl;
  logic        clk, rst_n, in_valid, out_ready;
  logic [11:0] D;
  logic        in_ready1, out_valid1, S1, sat1, in_ready0, out_valid0, S0, sat0;
  logic [2:0]  E1, E0;
  logic [3:0]  F1, F0;
  int n_assert = 0;
  int n_fail = 0;
  fpcvt_seq_ctrl #(.ROUND_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .D(D),
    .out_valid(out_valid1), .out_ready(out_ready), .S(S1), .E(E1), .F(F1), .sat(sat1));
  fpcvt_seq_ctrl #(.ROUND_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .D(D),
    .out_valid(out_valid0), .out_ready(out_ready), .S(S0), .E(E0), .F(F0), .sat(sat0));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask
  // value = F * 2^E with F holding the top four significant bits of |D|, then optional round-half-up
  function automatic void model(input logic [11:0] d, input bit ren,
                                output int s, output int e, output int f, output int st, output int k);
    int a, p, rb;
    a  = d == 12'h800 ? 2047 : d[11] ? 4096 - int'(d) : int'(d);
    s  = int'(d[11]);
    p  = -1;
    for (int i = 0; i < 11; i++) if ((a >> i) & 1) p = i;
    if (p >= 3) begin
      e  = p - 3;
      f  = a >> (p - 3);
      rb = (ren && p >= 4) ? (a >> (p - 4)) & 1 : 0;
      k  = 10 - p;
    end else begin
      e = 0; f = a; rb = 0; k = 7;
    end
    f  = f + rb;
    if (f == 16) begin f = 8; e = e + 1; end
    st = d == 12'h800 ? 1 : 0;
    if (e > 7) begin e = 7; f = 15; st = 1; end
  endfunction
  task automatic do_conv(input logic [11:0] d, input int hold);
    int s1, e1, f1, st1, k1, s0, e0, f0, st0, k0, w, lat;
    model(d, 1'b1, s1, e1, f1, st1, k1);
    model(d, 1'b0, s0, e0, f0, st0, k0);
    w = 0;
    while (!in_ready1 && w < 20) begin @(posedge clk); #1; w++; end
    check("in_ready_idle", in_ready1, 1);
    in_valid = 1'b1; D = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      in_valid = 1'($urandom);
      D = 12'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, k1 + 3);
    check("out_valid_r0", out_valid0, 1);
    check("in_ready_busy", in_ready1, 0);
    check("S_r1", S1, s1);
    check("E_r1", E1, e1);
    check("F_r1", F1, f1);
    check("sat_r1", sat1, st1);
    check("S_r0", S0, s0);
    check("E_r0", E0, e0);
    check("F_r0", F0, f0);
    check("sat_r0", sat0, st0);
    repeat (hold) begin
      in_valid = 1'b1;
      D = 12'($urandom);
      @(posedge clk); #1;
      check("hold_valid", out_valid1, 1);
      check("hold_ready", in_ready1, 0);
      check("hold_EF", {E1, F1}, {e1[2:0], f1[3:0]});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", out_valid1, 0);
    check("release_ready", in_ready1, 1);
    check("keep_SEF", {S1, E1, F1, sat1}, {s1[0], e1[2:0], f1[3:0], st1[0]});
  endtask
  initial begin
    logic [11:0] dir [7];
    dir = '{12'd5, 12'd35, 12'd62, 12'd2047, 12'h800, 12'hFED, 12'd0};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; D = '0;
    #12;
    check("rst_valid", out_valid1, 0);
    check("rst_SEF", {S1, E1, F1, sat1}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready1, 1);
    foreach (dir[i]) do_conv(dir[i], 0);
    do_conv(12'd35, 5);
    for (int i = 0; i < 40; i++) do_conv(12'($urandom), int'($urandom_range(0, 2)));
    do_conv(12'hFED, 0);
    in_valid = 1'b1; D = 12'd35;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid1, 0);
    check("arst_SEF", {S1, E1, F1, sat1}, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_in_ready", in_ready1, 1);
    check("arst_no_out", out_valid1, 0);
    do_conv(12'd35, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
